// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready pipeline register chain with flush and occupancy.
// Retimes long datapath paths and absorbs downstream stalls.
module pipe_reg_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      adv;
  logic [DEPTH-1:0]      src_v;
  logic [DATA_WIDTH-1:0] d     [DEPTH];
  logic [DATA_WIDTH-1:0] src_d [DEPTH];
  logic                  in_xfer;
  logic                  out_xfer;
  logic [CNT_WIDTH-1:0]  occ;

  // A stage advances when it or any stage above it is empty,
  // or the sink takes a word; unrolled to avoid a comb self-loop.
  always_comb begin
    logic full_above;
    full_above = 1'b1;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_above = full_above & v[i];
      adv[i] = ~full_above | out_ready;
    end
  end

  assign in_ready  = adv[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = occ;

  always_comb begin
    src_v    = '0;
    src_v[0] = in_xfer;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) v[i] <= src_v[i];
      end
    end
  end

  // Data only moves with a valid word; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= occ + CNT_WIDTH'(in_xfer) - CNT_WIDTH'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (DEPTH=3, 16-bit data).
// Driver pushes accepted words; a negedge monitor pops and compares.
module tb_pipe_reg_chain;

  localparam int DW = 16;
  localparam int DP = 3;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] occupancy;

  pipe_reg_chain #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int            pend = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: words in the chain are exactly the queue minus
  // the one pushed this cycle (it enters on the next edge).
  always @(negedge clk) begin
    if (!reset) begin
      chk("occupancy", 32'(occupancy), 32'(q.size()) - 32'(pend));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(q.pop_front()));
        end
      end
    end
  end

  task automatic step(input logic iv, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    pend = 0;
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    flush = fl;
    #3;
    if (iv && in_ready && !fl) begin
      q.push_back(id);
      pend = 1;
    end
    if (fl) begin
      #2;
      q.delete();
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming: first word visible three cycles after its transfer.
    step(1'b1, 16'h0011, 1'b1, 1'b0);
    chk("lat_c0", 32'(out_valid), 0);
    step(1'b1, 16'h0022, 1'b1, 1'b0);
    chk("lat_c1", 32'(out_valid), 0);
    step(1'b1, 16'h0033, 1'b1, 1'b0);
    chk("lat_c2", 32'(out_valid), 0);
    step(1'b1, 16'h0044, 1'b1, 1'b0);
    chk("lat_c3", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h11);
    chk("peak_occ", 32'(occupancy), 3);
    idle(4, 1'b1);
    chk("stream_drained", 32'(q.size()), 0);

    // Backpressure: three accepted, then stall, then pass-through.
    step(1'b1, 16'h00A0, 1'b0, 1'b0);
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b0);
    step(1'b1, 16'h00A3, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_occ", 32'(occupancy), 3);
    step(1'b1, 16'h00A3, 1'b0, 1'b0);
    chk("full_hold", 32'(out_data), 32'hA0);
    step(1'b1, 16'h00A3, 1'b1, 1'b0);
    chk("pass_in_ready", 32'(in_ready), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pass_occ", 32'(occupancy), 3);
    chk("pass_next", 32'(out_data), 32'hA1);
    step(1'b1, 16'h00A4, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Bubbles collapse under stall.
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 16'h0006, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bub_occ", 32'(occupancy), 2);
    chk("bub_in_ready", 32'(in_ready), 1);
    chk("bub_out_data", 32'(out_data), 32'h5);
    idle(4, 1'b1);

    // Flush a full chain with an offered word.
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    step(1'b1, 16'hCAFE, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_occ", 32'(occupancy), 0);
    idle(5, 1'b1);

    // Asynchronous reset mid-stream.
    step(1'b1, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    pend = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_data", 32'(out_data), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_in_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 16'h0077, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("ar_lat_early", 32'(out_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ar_lat_valid", 32'(out_valid), 1);
    chk("ar_lat_data", 32'(out_data), 32'h77);
    idle(3, 1'b1);

    // Random valid/ready/flush traffic.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    idle(6, 1'b1);
    chk("final_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register: DEPTH stages of DATA_WIDTH-bit registers with a valid/ready handshake on both sides.
- Generalises the plain enabled register with per-stage valid tracking, backpressure, synchronous flush and an occupancy count.
- Sits between LeNet5 datapath blocks (conv, pool, FC) to retime long paths and absorb downstream stalls without losing data.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- DEPTH, 2, number of register stages (legal range 1..16).
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream word present.
- in_data  input  DATA_WIDTH  upstream word.
- in_ready  output  1  chain can accept a word this cycle.
- out_valid  output  1  stage DEPTH-1 holds a valid word.
- out_data  output  DATA_WIDTH  word in stage DEPTH-1.
- out_ready  input  1  downstream accepts the word this cycle.
- occupancy  output  CNT_WIDTH  number of valid stages, 0..DEPTH.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. While reset is high:
  - all stage valids = 0, all stage data = 0;
  - out_valid = 0, out_data = 0, occupancy = 0;
  - in_ready = 1 (combinational result of empty stages).
- Stage i holds {v[i], d[i]}. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Advance rule (combinational):
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[i] = ~v[i] | adv[i+1] for i < DEPTH-1.
  - in_ready = adv[0].
- On each rising clk, every stage with adv[i] = 1 loads from its predecessor:
  - stage 0 loads v = in_valid & in_ready and d = in_data;
  - stage i loads v[i-1] and d[i-1].
  - A stage with adv = 0 holds its contents.
- d[i] loads only when the incoming valid = 1, which saves power. Data is don't-care when valid = 0 but never X after reset.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - A word is never dropped or duplicated.
- Latency and throughput:
  - Unstalled latency is DEPTH cycles from input transfer to out_valid.
  - Throughput is 1 word per cycle when out_ready is held high.
- Full chain (all v = 1) with out_ready = 0: in_ready = 0 and all stages hold.
- Full chain with out_ready = 1: the whole chain shifts, and in_ready = 1 in the same cycle (ready passes combinationally through the chain).
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Flush:
  - On a clk edge with flush = 1, all v are cleared to 0.
  - Any input offered that cycle is discarded, even if in_ready = 1. Upstream is told it was accepted, so flush is a drop-everything operation.
  - A simultaneous output transfer still counts as delivered.
  - d registers are not cleared by flush.
- Occupancy:
  - Registered count of valid stages, updated every edge: +1 on input transfer, -1 on output transfer, unchanged on both or neither.
  - Forced to 0 on flush or reset.
  - Must always equal the popcount of v.
- Reset asserted mid-stream clears everything immediately, without waiting for a clock. After deassertion the first edge behaves as an empty chain.
- DEPTH = 1 degenerates to a single stage with the same handshake rules.

Test Plan:
- DEPTH=3, out_ready=1; stream 0x11,0x22,0x33,0x44 on consecutive cycles -> out_valid rises 3 cycles after the first transfer, words appear in order on consecutive cycles, occupancy peaks at 3.
- DEPTH=3, out_ready=0; offer 0xA0..0xA4 -> exactly 3 accepted (0xA0..0xA2), in_ready=0 from the 4th cycle, occupancy=3; then raise out_ready for 1 cycle -> 0xA0 delivered, 0xA3 accepted in the same cycle, occupancy stays 3.
- DEPTH=4; one word 0x5, then 2 idle cycles, then 0x6, with out_ready=0 -> bubbles collapse, both words reach stages 3 and 2 respectively, occupancy=2, in_ready=1.
- Full DEPTH=2 chain holding 0xDEAD,0xBEEF; assert flush with in_valid=1 and in_data=0x1234 -> next cycle out_valid=0, occupancy=0, 0x1234 never appears at the output.
- Assert reset asynchronously between clock edges while occupancy=2 -> out_valid, out_data and occupancy go to 0 before the next edge; after release, 0x77 emerges after DEPTH cycles.
- Random valid/ready toggling for 10k cycles with a scoreboard -> output order matches input order, no loss or duplication, occupancy == popcount(v) every cycle.
